video_coord: RTL

- Upstream stage of the block-luminance/inversion pipeline on the HDMI-in pixel clock.
- Registers the sil9013 sync/data stream, derives per-pixel coordinates (x, y, block column/row, in-block phase) and start-of-line/frame strobes, all aligned with a one-cycle-delayed copy of the video.
- Checks the incoming geometry against the expected frame size and reports lock, so downstream block accumulation and inversion run only on valid frames.

---
 rtl/video_coord.sv | 292 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/video_coord.sv
// -----------------------------------------------------------------------------
// video_coord
// Front end of the block-luminance / inversion pipeline, clocked by the HDMI-in
// pixel clock. It registers the incoming sync/data stream and generates
// coordinates, strobes and geometry information that line up with the delayed
// copy of the video. It also checks the frame geometry and reports whether the
// input is locked.
//
// Ports:
//   clk_i, rst_ni         pixel clock; synchronous active-low reset
//   vin_hs_i/vs_i/de_i    incoming syncs and data enable (active high)
//   vin_data_i            incoming RGB {R,G,B}
//   vout_hs_o/vs_o/de_o   syncs and data enable, delayed by one cycle
//   vout_data_o           RGB, delayed by one cycle
//   x_o, y_o              pixel index in the line, active line index in the frame
//   hp_o, hb_o            x mod KN, x div KN
//   vp_o, vb_o            y mod KN, y div KN
//   sol_o, sof_o          first active pixel of a line / of a frame
//   line_done_o           pulse on the cycle after the last active pixel of a line
//   width_o               pixel count of the last completed line
//   height_o              active line count of the last completed frame
//   locked_o              geometry has matched WN x HN on consecutive frames
// -----------------------------------------------------------------------------
module video_coord #(
   parameter int WN  = 1920,
   parameter int HN  = 1080,
   parameter int KN  = 10,
   parameter int CW  = 12,
   parameter int TMO = 4000000
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          vin_hs_i,
   input  logic          vin_vs_i,
   input  logic          vin_de_i,
   input  logic [23:0]   vin_data_i,
   output logic          vout_hs_o,
   output logic          vout_vs_o,
   output logic          vout_de_o,
   output logic [23:0]   vout_data_o,
   output logic [CW-1:0] x_o,
   output logic [CW-1:0] y_o,
   output logic [CW-1:0] hp_o,
   output logic [CW-1:0] hb_o,
   output logic [CW-1:0] vp_o,
   output logic [CW-1:0] vb_o,
   output logic          sol_o,
   output logic          sof_o,
   output logic          line_done_o,
   output logic [CW-1:0] width_o,
   output logic [CW-1:0] height_o,
   output logic          locked_o
);

   localparam int WDW = $clog2(TMO + 1);
   localparam logic [CW-1:0]  CMAX   = '1;
   localparam logic [CW-1:0]  KLAST  = CW'(KN - 1);
   localparam logic [WDW-1:0] WDLAST = WDW'(TMO - 1);
   localparam logic [WDW-1:0] WDEND  = WDW'(TMO);

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      CHECK    = 2'd1,
      LOCKED   = 2'd2
   } lock_state_e;

   logic          hs_q, hs_d;
   logic          vs_q, vs_d;
   logic          de_q, de_d;
   logic [23:0]   data_q, data_d;
   logic [CW-1:0] x_q, x_d;
   logic [CW-1:0] y_q, y_d;
   logic [CW-1:0] hp_q, hp_d;
   logic [CW-1:0] hb_q, hb_d;
   logic [CW-1:0] vp_q, vp_d;
   logic [CW-1:0] vb_q, vb_d;
   logic          sol_q, sol_d;
   logic          sof_q, sof_d;
   logic          line_done_q, line_done_d;
   logic [CW-1:0] width_q, width_d;
   logic [CW-1:0] height_q, height_d;
   logic          locked_q, locked_d;
   lock_state_e   state_q, state_d;
   logic          seen_vs_q, seen_vs_d;
   logic          first_line_q, first_line_d;
   logic          frame_bad_q, frame_bad_d;
   logic [CW-1:0] line_cnt_q, line_cnt_d;
   logic [CW-1:0] pix_cnt_q, pix_cnt_d;
   logic [WDW-1:0] wd_q, wd_d;

   logic          act_in;
   logic          act_prev;
   logic          vs_rise;
   logic          line_start;
   logic          line_end;
   logic [CW-1:0] lines_total;
   logic          bad_total;
   logic          frame_good;

   always_comb begin
      // An active pixel is DE with VS low; DE during VS is passed through but
      // never treated as picture content.
      act_in     = vin_de_i & ~vin_vs_i;
      act_prev   = de_q & ~vs_q;
      vs_rise    = vin_vs_i & ~vs_q;
      line_start = act_in & ~act_prev;
      line_end   = act_prev & ~act_in;

      hs_d         = vin_hs_i;
      vs_d         = vin_vs_i;
      de_d         = vin_de_i;
      data_d       = vin_data_i;
      x_d          = x_q;
      y_d          = y_q;
      hp_d         = hp_q;
      hb_d         = hb_q;
      vp_d         = vp_q;
      vb_d         = vb_q;
      sol_d        = 1'b0;
      sof_d        = 1'b0;
      line_done_d  = 1'b0;
      width_d      = width_q;
      height_d     = height_q;
      state_d      = state_q;
      seen_vs_d    = seen_vs_q;
      first_line_d = first_line_q;
      line_cnt_d   = line_cnt_q;
      pix_cnt_d    = pix_cnt_q;
      wd_d         = wd_q;

      // A line that ends on the same cycle as the VS rise still belongs to
      // the frame that is being evaluated, so fold it in before evaluation.
      lines_total = line_cnt_q;
      bad_total   = frame_bad_q;
      if (line_end) begin
         line_done_d = 1'b1;
         width_d     = pix_cnt_q;
         if (pix_cnt_q != CW'(WN)) begin
            bad_total = 1'b1;
         end
         if (line_cnt_q != CMAX) begin
            lines_total = line_cnt_q + 1'b1;
         end
      end
      if (vin_de_i & vin_vs_i) begin
         bad_total = 1'b1;
      end
      line_cnt_d  = lines_total;
      frame_bad_d = bad_total;

      if (line_start) begin
         x_d       = '0;
         hp_d      = '0;
         hb_d      = '0;
         sol_d     = 1'b1;
         pix_cnt_d = CW'(1);
         if (first_line_q) begin
            y_d          = '0;
            vp_d         = '0;
            vb_d         = '0;
            sof_d        = 1'b1;
            first_line_d = 1'b0;
         end else if (y_q == CMAX) begin
            frame_bad_d = 1'b1;
         end else begin
            y_d = y_q + 1'b1;
            if (vp_q == KLAST) begin
               vp_d = '0;
               vb_d = vb_q + 1'b1;
            end else begin
               vp_d = vp_q + 1'b1;
            end
         end
      end else if (act_in) begin
         if (x_q == CMAX) begin
            frame_bad_d = 1'b1;
         end else begin
            x_d = x_q + 1'b1;
            if (hp_q == KLAST) begin
               hp_d = '0;
               hb_d = hb_q + 1'b1;
            end else begin
               hp_d = hp_q + 1'b1;
            end
         end
         if (pix_cnt_q != CMAX) begin
            pix_cnt_d = pix_cnt_q + 1'b1;
         end
      end

      // The frame started after the previous VS rise; it is only trusted when
      // such a rise was seen since reset or since the last watchdog expiry.
      frame_good = seen_vs_q & ~bad_total & (lines_total == CW'(HN));

      if (vs_rise) begin
         height_d = lines_total;
         case (state_q)
            UNLOCKED: if (frame_good)  state_d = CHECK;
            CHECK:    state_d = frame_good ? LOCKED : UNLOCKED;
            LOCKED:   if (!frame_good) state_d = UNLOCKED;
            default:  state_d = UNLOCKED;
         endcase
         y_d          = '0;
         vp_d         = '0;
         vb_d         = '0;
         line_cnt_d   = '0;
         frame_bad_d  = 1'b0;
         first_line_d = 1'b1;
         seen_vs_d    = 1'b1;
         wd_d         = '0;
      end else if (wd_q == WDLAST) begin
         // The watchdog parks at TMO so that expiry is a single event.
         wd_d      = WDEND;
         state_d   = UNLOCKED;
         seen_vs_d = 1'b0;
      end else if (wd_q != WDEND) begin
         wd_d = wd_q + 1'b1;
      end

      locked_d = (state_d == LOCKED);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         hs_q         <= 1'b0;
         vs_q         <= 1'b0;
         de_q         <= 1'b0;
         data_q       <= '0;
         x_q          <= '0;
         y_q          <= '0;
         hp_q         <= '0;
         hb_q         <= '0;
         vp_q         <= '0;
         vb_q         <= '0;
         sol_q        <= 1'b0;
         sof_q        <= 1'b0;
         line_done_q  <= 1'b0;
         width_q      <= '0;
         height_q     <= '0;
         locked_q     <= 1'b0;
         state_q      <= UNLOCKED;
         seen_vs_q    <= 1'b0;
         first_line_q <= 1'b1;
         frame_bad_q  <= 1'b0;
         line_cnt_q   <= '0;
         pix_cnt_q    <= '0;
         wd_q         <= '0;
      end else begin
         hs_q         <= hs_d;
         vs_q         <= vs_d;
         de_q         <= de_d;
         data_q       <= data_d;
         x_q          <= x_d;
         y_q          <= y_d;
         hp_q         <= hp_d;
         hb_q         <= hb_d;
         vp_q         <= vp_d;
         vb_q         <= vb_d;
         sol_q        <= sol_d;
         sof_q        <= sof_d;
         line_done_q  <= line_done_d;
         width_q      <= width_d;
         height_q     <= height_d;
         locked_q     <= locked_d;
         state_q      <= state_d;
         seen_vs_q    <= seen_vs_d;
         first_line_q <= first_line_d;
         frame_bad_q  <= frame_bad_d;
         line_cnt_q   <= line_cnt_d;
         pix_cnt_q    <= pix_cnt_d;
         wd_q         <= wd_d;
      end
   end

   assign vout_hs_o   = hs_q;
   assign vout_vs_o   = vs_q;
   assign vout_de_o   = de_q;
   assign vout_data_o = data_q;
   assign x_o         = x_q;
   assign y_o         = y_q;
   assign hp_o        = hp_q;
   assign hb_o        = hb_q;
   assign vp_o        = vp_q;
   assign vb_o        = vb_q;
   assign sol_o       = sol_q;
   assign sof_o       = sof_q;
   assign line_done_o = line_done_q;
   assign width_o     = width_q;
   assign height_o    = height_q;
   assign locked_o    = locked_q;

endmodule
